shift_right_sequential: RTL and testbench
=========================================

Name: shift_right_sequential

Overview:
- Multi-cycle right shifter for the MIPS datapath. It is the opposite-direction companion to the combinational left-shift blocks, and serves SRL/SRA/SRLV/SRAV when the ALU takes the multi-cycle path.
- It accepts an operand and a shift amount through a start/done handshake, then shifts right one bit per clock, logically or arithmetically.
- It holds the result stable until the next accepted request.

Parameters:
- Data_Size, 32, operand/result width in bits.
- Shamt_Size, 5, shift-amount width; must equal ceil(log2(Data_Size)).

Ports:
- CLK  input  1  system clock, rising-edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  request strobe; sampled only in IDLE.
- ARITH  input  1  1 = arithmetic (sign-fill), 0 = logical (zero-fill); captured with START.
- SHAMT  input  Shamt_Size  shift amount, 0..Data_Size-1; captured with START.
- INPUT_SHIFTED  input  Data_Size  operand; captured with START.
- OUTPUT_SHIFTED  output  Data_Size  result register.
- BUSY  output  1  high while in SHIFT or DONE.
- DONE  output  1  one-cycle pulse; OUTPUT_SHIFTED is final while it is high.

Behaviour:
- Reset (async, RST=1): state=IDLE, OUTPUT_SHIFTED=0, BUSY=0, DONE=0, internal count=0, mode=0. Effective immediately, with no clock needed. On deassertion, the block starts in IDLE on the next rising edge.
- States: IDLE, SHIFT, DONE. All outputs are registered.
- IDLE:
  - On an edge with START=1: load OUTPUT_SHIFTED<=INPUT_SHIFTED, count<=SHAMT, mode<=ARITH.
  - Next state is SHIFT if SHAMT!=0, else DONE.
  - START=0: stay in IDLE, OUTPUT_SHIFTED holds.
- SHIFT:
  - Each edge: OUTPUT_SHIFTED <= {fill, OUTPUT_SHIFTED[Data_Size-1:1]} and count<=count-1.
  - fill = OUTPUT_SHIFTED[Data_Size-1] if mode=1, else 0. The sign is taken from the current register MSB, which stays invariant under sign-fill.
  - When count==1 at the edge, the last shift is done and next state is DONE.
- DONE: DONE=1 for exactly one cycle, then IDLE on the next edge. OUTPUT_SHIFTED holds.
- BUSY=1 in SHIFT and DONE, 0 in IDLE. DONE and BUSY are both high in the DONE cycle.
- Latency:
  - The result is valid, with DONE=1, after SHAMT+1 rising edges counting the START-sampling edge.
  - Throughput: one request per SHAMT+2 cycles. START may be asserted in the cycle DONE is high, but it is ignored; it is accepted only in IDLE.
- START while BUSY: ignored. No queueing, no error, in-flight operands are unaffected. Input changes after acceptance have no effect.
- SHAMT=0: result equals the operand; DONE is high on the cycle after acceptance. ARITH is irrelevant.
- SHAMT=Data_Size-1: the full range is supported.
  - Logical: result is 0 or 1 (the original MSB).
  - Arithmetic: result is all-ones or all-zeros.
- Arithmetic result equals the signed >>> reference for every operand and SHAMT; logical equals >>.
- OUTPUT_SHIFTED is stable from DONE until the next accepted START. It is overwritten on the acceptance edge and shows intermediate values during SHIFT; consumers must sample only on DONE.
- Reset mid-operation (SHIFT or DONE): abort immediately, all outputs 0, no DONE pulse for the aborted request.
- Count width is Shamt_Size; no wrap-around is possible since count only decrements from SHAMT to 0 in SHIFT.

Test Plan:
- Reset: RST=1 mid-SHIFT of 0xDEADBEEF by 20 -> OUTPUT_SHIFTED=0, BUSY=0, DONE=0 asynchronously. After release, IDLE with no DONE pulse.
- Logical: START, INPUT_SHIFTED=0x80000000, SHAMT=4, ARITH=0 -> DONE on the 5th edge, OUTPUT_SHIFTED=0x08000000, BUSY high for edges 1..5 outputs.
- Arithmetic: INPUT_SHIFTED=0x80000000, SHAMT=31, ARITH=1 -> OUTPUT_SHIFTED=0xFFFFFFFF, DONE after 32 edges. Same operand with ARITH=0 -> 0x00000001.
- Zero shift: INPUT_SHIFTED=0x12345678, SHAMT=0 -> DONE on the next cycle, OUTPUT_SHIFTED=0x12345678.
- Busy collision: accept 0xF0F0F0F0>>8 logical, then pulse START with 0x1, SHAMT=1 during SHIFT and again during DONE -> result 0x00F0F0F0, single DONE pulse, second request not executed.
- Random: 1000 back-to-back requests, random operand/SHAMT/ARITH, START held high -> each DONE result matches the >>/>>> model, and spacing between DONEs equals SHAMT+2.

Source files
------------

// File: rtl/shift_right_sequential.sv
// Multi-cycle right shifter: accepts an operand on START and shifts it right
// one bit per clock (logical or arithmetic), pulsing DONE when the result is final.
module shift_right_sequential #(
  parameter int unsigned Data_Size  = 32,
  parameter int unsigned Shamt_Size = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  ARITH,
  input  logic [Shamt_Size-1:0] SHAMT,
  input  logic [Data_Size-1:0]  INPUT_SHIFTED,
  output logic [Data_Size-1:0]  OUTPUT_SHIFTED,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int unsigned MsbIdx = Data_Size - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [Data_Size-1:0]    data_q,  data_d;
  logic [Shamt_Size-1:0]   count_q, count_d;
  logic                    mode_q,  mode_d;
  logic                    busy_q,  busy_d;
  logic                    done_q,  done_d;
  logic                    fill;

  // State and datapath registers; reset aborts any request in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath; the sign bit is invariant under sign-fill.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    count_d = count_q;
    mode_d  = mode_q;
    fill    = mode_q & data_q[MsbIdx];

    case (state_q)
      S_IDLE: begin
        if (START) begin
          data_d  = INPUT_SHIFTED;
          count_d = SHAMT;
          mode_d  = ARITH;
          state_d = (SHAMT != '0) ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        data_d  = {fill, data_q[MsbIdx:1]};
        count_d = count_q - Shamt_Size'(1);
        if (count_q == Shamt_Size'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered alongside the state they describe.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign OUTPUT_SHIFTED = data_q;
  assign BUSY           = busy_q;
  assign DONE           = done_q;

endmodule

// File: tb/tb_shift_right_sequential.sv
// Directed and randomized self-checking bench for shift_right_sequential.
module tb_shift_right_sequential;

  logic        clk;
  logic        rst;
  logic        start;
  logic        arith;
  logic [4:0]  shamt;
  logic [31:0] din;
  logic [31:0] dout;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  shift_right_sequential #(.Data_Size(32), .Shamt_Size(5)) dut (
    .CLK            (clk),
    .RST            (rst),
    .START          (start),
    .ARITH          (arith),
    .SHAMT          (shamt),
    .INPUT_SHIFTED  (din),
    .OUTPUT_SHIFTED (dout),
    .BUSY           (busy),
    .DONE           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s, input logic a);
    logic signed [31:0] sd;
    sd = d;
    if (a) model = 32'(sd >>> s);
    else   model = d >> s;
  endfunction

  // Drive one request at a falling edge, hold START for one edge, wait for DONE.
  task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                        output logic [31:0] res, output int edges, output bit busy_all,
                        output bit timed_out);
    edges     = 0;
    busy_all  = 1'b1;
    timed_out = 1'b1;
    start = 1'b1; din = d; shamt = s; arith = a;
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      start = 1'b0;
      if (!busy) busy_all = 1'b0;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
    end
    res = dout;
  endtask

  // Directed request with result, latency, BUSY and post-DONE behaviour checked.
  task automatic directed(input string tag, input logic [31:0] d, input logic [4:0] s,
                          input logic a, input logic [31:0] exp);
    logic [31:0] res;
    int          edges;
    bit          busy_all, to;
    run_op(d, s, a, res, edges, busy_all, to);
    check({tag, "_timeout"}, 32'(to), 32'd0);
    check({tag, "_result"}, res, exp);
    check({tag, "_edges"}, 32'(edges), 32'(s) + 32'd1);
    check({tag, "_busy"}, 32'(busy_all), 32'd1);
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, dout, exp);
  endtask

  initial begin : main
    logic [31:0] res;
    int          edges, ndone;
    bit          busy_all, to, bad;
    logic [31:0] cur_d;
    logic [4:0]  cur_s;
    logic        cur_a;
    int          prev_done;

    rst = 1'b1; start = 1'b0; arith = 1'b0; shamt = '0; din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out", dout, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);

    directed("lsr4",    32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000);
    directed("asr31",   32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF);
    directed("lsr31",   32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
    directed("zero",    32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678);
    directed("asr4neg", 32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000);
    directed("asr4pos", 32'h7FFF_FFF0, 5'd4,  1'b1, 32'h07FF_FFFF);
    directed("asr31p",  32'h7FFF_FFFF, 5'd31, 1'b1, 32'h0000_0000);

    // Reset in the middle of a shift.
    start = 1'b1; din = 32'hDEAD_BEEF; shamt = 5'd20; arith = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out", dout, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done || busy) bad = 1'b1;
    end
    check("mid_rst_no_done", 32'(bad), 32'd0);

    // Collision: START during SHIFT and during DONE is ignored.
    start = 1'b1; din = 32'hF0F0_F0F0; shamt = 5'd8; arith = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; din = 32'h0000_0001; shamt = 5'd1; arith = 1'b1;
    @(negedge clk);
    start = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("coll_timeout", 32'(to), 32'd0);
    check("coll_result", dout, 32'h00F0_F0F0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (20) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("coll_extra_done", 32'(ndone), 32'd0);
    check("coll_hold", dout, 32'h00F0_F0F0);
    check("coll_idle", 32'(busy), 32'd0);

    // Back-to-back random requests with START held high.
    cur_d = $urandom; cur_s = 5'($urandom_range(0, 31)); cur_a = 1'($urandom);
    din = cur_d; shamt = cur_s; arith = cur_a; start = 1'b1;
    prev_done = 0;
    for (int i = 0; i < 1000; i++) begin
      to = 1'b1;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done) begin
          to = 1'b0;
          break;
        end
      end
      if (to) begin
        check("rnd_timeout", 32'(to), 32'd0);
        break;
      end
      check($sformatf("rnd%0d_result", i), dout, model(cur_d, cur_s, cur_a));
      if (i > 0) check($sformatf("rnd%0d_spacing", i), 32'(cyc - prev_done), 32'(cur_s) + 32'd2);
      prev_done = cyc;
      cur_d = $urandom; cur_s = 5'($urandom_range(0, 31)); cur_a = 1'($urandom);
      din = cur_d; shamt = cur_s; arith = cur_a;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
